pipe_hazard_unit: RTL and testbench
===================================

Name: pipe_hazard_unit

Overview:
- ID-stage producer of the forwarding-select and stall/bubble controls that the ID/EX pipeline register carries into EX.
- Keeps its own shadow scoreboard of E- and M-stage destinations.
- Detects load-use and multi-cycle-MDU hazards and handles taken-branch flushes.
- Emits 2-bit dependency codes per source operand, plus saturating stall and flush counters for performance debug.

Parameters:
MDU_LAT, 4, cycles an MDU op stays busy after leaving D (2..15)
CNT_W, 16, width of the stall and flush performance counters

Ports:
clk  in  1  rising-edge clock
clrn  in  1  asynchronous active-low reset
d_valid  in  1  D holds a real instruction
d_rs  in  5  source A register
d_rt  in  5  source B register
d_rn  in  5  destination register
d_wreg  in  1  D writes the register file
d_m2reg  in  1  D is a load
d_use_rs  in  1  ALU A reads rs
d_use_rt  in  1  ALU B reads rt
d_is_store  in  1  rt is store data
d_mdu  in  1  D is a multi-cycle MDU op
e_branch_taken  in  1  branch/jump resolved taken in E
dadepen  out  2  ALU A source select
dbdepen  out  2  ALU B source select
dsdepen  out  2  store-data source select
d_stall  out  1  hold PC and IF/ID this cycle
d_bubble  out  1  load NOP into ID/EX: dwreg=dwmem=0
d_flush  out  1  nullify IF/ID contents
mdu_busy  out  1  MDU in flight
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of flush cycles

Behaviour:
- Reset (clrn=0, async): E/M slots cleared (rn=0, wreg=0, m2reg=0), FSM=IDLE, busy counter=0, both counters=0. All outputs are 0 during reset.
- Dependency code (shared package): 00 = regfile, 01 = E ALU result, 10 = M ALU result, 11 = M memory data.
- Per source (rs→dadepen, rt→dbdepen, rt→dsdepen):
  - Code is 00 if the source is unused, is r0, or D is not valid.
  - Else if E.wreg and E.rn matches and E is not a load: 01.
  - Else if M.wreg and M.rn matches: 11 if M.m2reg, else 10.
  - Else 00. E has priority over M.
- Load-use stall: E.m2reg && E.wreg && E.rn≠0 and the E.rn matches a used source (rs via d_use_rs; rt via d_use_rt or d_is_store). Response: d_stall=1, d_bubble=1 for exactly one cycle. Next cycle the load is in M and the code is 11.
- MDU FSM (IDLE, BUSY):
  - IDLE → BUSY when a valid, unstalled d_mdu instruction leaves D. Busy counter loads MDU_LAT, and its rn is latched as mdu_rn.
  - In BUSY: counter decrements each cycle, mdu_busy=1. At counter==1 → IDLE.
  - While BUSY, D stalls (d_stall=1, d_bubble=1) if it reads mdu_rn (r0 exempt) or is another d_mdu.
- Taken branch: e_branch_taken=1 gives d_flush=1 and d_bubble=1; d_stall is forced 0. Flush has priority over every stall.
- Branch in E while the MDU is BUSY: the MDU continues; already-issued ops are never killed.
- Slot update each rising edge:
  - M ← E.
  - E ← 0 if d_bubble or !d_valid.
  - Otherwise E ← {d_rn, d_wreg, d_m2reg}.
- Counters:
  - stall_cnt increments on any cycle with d_stall=1.
  - flush_cnt increments on any cycle with d_flush=1.
  - Both saturate at all-ones and never wrap.
- Reset mid-operation (BUSY or mid-stall): everything returns to reset state immediately; no pending stall survives.
- Outputs dadepen/dbdepen/dsdepen/d_stall/d_bubble/d_flush are combinational from inputs and internal state. All state changes on the rising clk edge only.

Decomposition:
- Package pipe_hazard_pkg: depen encoding constants (DEP_RF, DEP_EALU, DEP_MALU, DEP_MMEM), FSM state encoding, struct for a scoreboard slot {rn, wreg, m2reg}.
- One sub-module: hazard_fwd_sel, a purely combinational per-operand code generator, instantiated three times.

Test Plan:
- Back-to-back ALU: add r3 then sub r4,r3,r1. Required: dadepen=01, no stall. One cycle later with a NOP between: dadepen=10.
- Load-use: lw r5 then add r6,r5,r2. Required: d_stall=1 and d_bubble=1 for one cycle, stall_cnt=1. Next cycle dadepen=11.
- Store data after load: lw r7 then sw r7. Required: one stall, then dsdepen=11 with dbdepen=00.
- MDU with MDU_LAT=4: mdu writing r8, then add r9,r8,r0. Required: mdu_busy high for 4 cycles, d_stall high for those 4 cycles, then forward code 00 with release.
- Branch taken while D has a load-use hazard. Required: d_flush=1, d_stall=0, flush_cnt=1, E slot zero next cycle.
- Assert clrn low while BUSY with a stall pending. Required: all outputs and counters are 0 immediately; after release, the first dependent instruction is not stalled.

Source files
------------

// File: rtl/pipe_hazard_pkg.sv
// Shared definitions for the ID-stage hazard unit: forwarding-select codes,
// MDU tracker states and the shape of one shadow-scoreboard slot.
package pipe_hazard_pkg;

   // Operand source select carried into EX
   typedef logic [1:0] depen_t;
   localparam depen_t DEP_RF   = 2'b00;  // register file value
   localparam depen_t DEP_EALU = 2'b01;  // ALU result currently in E
   localparam depen_t DEP_MALU = 2'b10;  // ALU result currently in M
   localparam depen_t DEP_MMEM = 2'b11;  // load data currently in M

   // Multi-cycle MDU tracker
   typedef enum logic {
      MDU_IDLE = 1'b0,
      MDU_BUSY = 1'b1
   } mdu_state_t;

   // One shadow-scoreboard entry: what the instruction in a stage will write
   typedef struct packed {
      logic [4:0] rn;
      logic       wreg;
      logic       m2reg;
   } slot_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Combinational forwarding-select for one source operand. E outranks M; a
// load sitting in E cannot forward (that case is a load-use stall instead).
module hazard_fwd_sel
   import pipe_hazard_pkg::*;
(
   input  logic       d_valid,
   input  logic [4:0] src,
   input  logic       use_src,
   input  slot_t      e_slot,
   input  slot_t      m_slot,
   output depen_t     depen
);

   // Pick the youngest producer of src; r0 and unused operands read the regfile
   always_comb begin
      depen = DEP_RF;
      if (d_valid && use_src && (src != 5'd0)) begin
         if (e_slot.wreg && !e_slot.m2reg && (e_slot.rn == src))
            depen = DEP_EALU;
         else if (m_slot.wreg && (m_slot.rn == src))
            depen = m_slot.m2reg ? DEP_MMEM : DEP_MALU;
      end
   end

endmodule

// File: rtl/pipe_hazard_unit.sv
// ID-stage hazard unit: forwarding selects, load-use and MDU stalls, taken
// branch flush, and saturating stall/flush counters for performance debug.
module pipe_hazard_unit
   import pipe_hazard_pkg::*;
#(
   parameter int MDU_LAT = 4,
   parameter int CNT_W   = 16
)(
   input  logic             clk,
   input  logic             clrn,
   input  logic             d_valid,
   input  logic [4:0]       d_rs,
   input  logic [4:0]       d_rt,
   input  logic [4:0]       d_rn,
   input  logic             d_wreg,
   input  logic             d_m2reg,
   input  logic             d_use_rs,
   input  logic             d_use_rt,
   input  logic             d_is_store,
   input  logic             d_mdu,
   input  logic             e_branch_taken,
   output logic [1:0]       dadepen,
   output logic [1:0]       dbdepen,
   output logic [1:0]       dsdepen,
   output logic             d_stall,
   output logic             d_bubble,
   output logic             d_flush,
   output logic             mdu_busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int                BCNT_W    = 4;
   localparam logic [BCNT_W-1:0] BCNT_LOAD = BCNT_W'(MDU_LAT);
   localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   slot_t             e_slot_p0;
   slot_t             m_slot_p1;
   mdu_state_t        state;
   mdu_state_t        state_nx;
   logic [BCNT_W-1:0] bcnt;
   logic [BCNT_W-1:0] bcnt_nx;
   logic [4:0]        mdu_rn;
   logic [4:0]        mdu_rn_nx;
   logic              rt_read;
   logic              lu_hit;
   logic              mdu_hit;
   logic              stall_raw;
   logic              flush_raw;
   logic              mdu_issue;
   depen_t            depen_a;
   depen_t            depen_b;
   depen_t            depen_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   hazard_fwd_sel u_sel_a (
      .d_valid (d_valid),
      .src     (d_rs),
      .use_src (d_use_rs),
      .e_slot  (e_slot_p0),
      .m_slot  (m_slot_p1),
      .depen   (depen_a)
   );

   hazard_fwd_sel u_sel_b (
      .d_valid (d_valid),
      .src     (d_rt),
      .use_src (d_use_rt),
      .e_slot  (e_slot_p0),
      .m_slot  (m_slot_p1),
      .depen   (depen_b)
   );

   hazard_fwd_sel u_sel_s (
      .d_valid (d_valid),
      .src     (d_rt),
      .use_src (d_is_store),
      .e_slot  (e_slot_p0),
      .m_slot  (m_slot_p1),
      .depen   (depen_s)
   );

   assign dadepen = depen_a;
   assign dbdepen = depen_b;
   assign dsdepen = depen_s;

   // Stall sources: a load in E feeding D, or D touching the in-flight MDU op
   always_comb begin
      rt_read   = d_use_rt | d_is_store;
      lu_hit    = d_valid && e_slot_p0.wreg && e_slot_p0.m2reg &&
                  (e_slot_p0.rn != 5'd0) &&
                  ((d_use_rs && (d_rs == e_slot_p0.rn)) ||
                   (rt_read  && (d_rt == e_slot_p0.rn)));
      mdu_hit   = (state == MDU_BUSY) && d_valid &&
                  (d_mdu || ((mdu_rn != 5'd0) &&
                             ((d_use_rs && (d_rs == mdu_rn)) ||
                              (rt_read  && (d_rt == mdu_rn)))));
      stall_raw = lu_hit | mdu_hit;
      // branch input is masked so every output is low while reset is held
      flush_raw = clrn & e_branch_taken;
   end

   // Flush wins over any stall: the stalled instruction is discarded anyway
   assign d_flush   = flush_raw;
   assign d_bubble  = flush_raw | stall_raw;
   assign d_stall   = stall_raw & ~flush_raw;
   assign mdu_busy  = (state == MDU_BUSY);
   assign mdu_issue = d_valid & d_mdu & ~d_bubble & (state == MDU_IDLE);

   // MDU tracker next state: arm on issue, count down, release at 1
   always_comb begin
      state_nx  = state;
      bcnt_nx   = bcnt;
      mdu_rn_nx = mdu_rn;
      case (state)
         MDU_IDLE: begin
            if (mdu_issue) begin
               state_nx  = MDU_BUSY;
               bcnt_nx   = BCNT_LOAD;
               mdu_rn_nx = d_rn;
            end
         end
         MDU_BUSY: begin
            bcnt_nx = bcnt - BCNT_ONE;
            if (bcnt == BCNT_ONE)
               state_nx = MDU_IDLE;
         end
         default: begin
            state_nx = MDU_IDLE;
            bcnt_nx  = '0;
         end
      endcase
   end

   // MDU tracker state register
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state  <= MDU_IDLE;
         bcnt   <= '0;
         mdu_rn <= '0;
      end else begin
         state  <= state_nx;
         bcnt   <= bcnt_nx;
         mdu_rn <= mdu_rn_nx;
      end
   end

   // D -> E -> M shadow scoreboard; bubbles and invalid slots enter as empty
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         e_slot_p0 <= '0;
         m_slot_p1 <= '0;
      end else begin
         m_slot_p1 <= e_slot_p0;
         if (d_bubble || !d_valid)
            e_slot_p0 <= '0;
         else
            e_slot_p0 <= '{rn: d_rn, wreg: d_wreg, m2reg: d_m2reg};
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (d_stall) stall_cnt <= sat_inc(stall_cnt);
         if (d_flush) flush_cnt <= sat_inc(flush_cnt);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed vector table, corner sequences
// (branch over busy MDU, reset mid-stall), then random traffic against an
// instruction-history reference model.
module tb_pipe_hazard_unit;

   localparam int LAT = 4;
   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;

   logic          clk;
   logic          clrn;
   logic          d_valid;
   logic [4:0]    d_rs, d_rt, d_rn;
   logic          d_wreg, d_m2reg, d_use_rs, d_use_rt, d_is_store, d_mdu;
   logic          e_branch_taken;
   logic [1:0]    dadepen, dbdepen, dsdepen;
   logic          d_stall, d_bubble, d_flush, mdu_busy;
   logic [CW-1:0] stall_cnt, flush_cnt;

   pipe_hazard_unit #(.MDU_LAT(LAT), .CNT_W(CW)) dut (
      .clk(clk), .clrn(clrn), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
      .d_rn(d_rn), .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_use_rs(d_use_rs),
      .d_use_rt(d_use_rt), .d_is_store(d_is_store), .d_mdu(d_mdu),
      .e_branch_taken(e_branch_taken), .dadepen(dadepen), .dbdepen(dbdepen),
      .dsdepen(dsdepen), .d_stall(d_stall), .d_bubble(d_bubble),
      .d_flush(d_flush), .mdu_busy(mdu_busy), .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   typedef struct packed {
      logic       v;
      logic [4:0] rs, rt, rn;
      logic       wreg, m2reg, urs, urt, st, mdu, br;
   } din_t;

   typedef struct {
      din_t       in;
      logic [1:0] a, b, s;
      logic       stall, flush, busy;
   } vec_t;

   typedef struct {
      logic [4:0] rn;
      logic       wreg, m2reg;
   } rec_t;

   typedef struct {
      int a, b, s, stall, bubble, flush, busy, sc, fc;
   } exp_t;

   int checks = 0;
   int errors = 0;

   // reference model: history of what left D (index 0 = one cycle ago)
   rec_t hist[$];
   int   t;
   int   mdu_end;
   logic [4:0] mdu_reg;
   int   m_sc, m_fc;

   vec_t vec[20];

   function automatic din_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rn, input logic wreg, input logic m2reg,
                               input logic urs, input logic urt, input logic st,
                               input logic mdu, input logic br);
      din_t x;
      x.v = v; x.rs = rs; x.rt = rt; x.rn = rn; x.wreg = wreg; x.m2reg = m2reg;
      x.urs = urs; x.urt = urt; x.st = st; x.mdu = mdu; x.br = br;
      return x;
   endfunction

   function automatic din_t alu(input logic [4:0] rn, input logic [4:0] rs, input logic [4:0] rt);
      return mk(1, rs, rt, rn, 1, 0, 1, 1, 0, 0, 0);
   endfunction
   function automatic din_t ld(input logic [4:0] rn, input logic [4:0] rs);
      return mk(1, rs, 5'd0, rn, 1, 1, 1, 0, 0, 0, 0);
   endfunction
   function automatic din_t sw(input logic [4:0] rt, input logic [4:0] rs);
      return mk(1, rs, rt, 5'd0, 0, 0, 1, 0, 1, 0, 0);
   endfunction
   function automatic din_t mduop(input logic [4:0] rn, input logic [4:0] rs, input logic [4:0] rt);
      return mk(1, rs, rt, rn, 1, 0, 1, 1, 0, 1, 0);
   endfunction
   function automatic din_t nop();
      return mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
   endfunction
   function automatic din_t withbr(input din_t x);
      din_t y;
      y = x;
      y.br = 1'b1;
      return y;
   endfunction

   task automatic drive(input din_t x);
      d_valid = x.v; d_rs = x.rs; d_rt = x.rt; d_rn = x.rn; d_wreg = x.wreg;
      d_m2reg = x.m2reg; d_use_rs = x.urs; d_use_rt = x.urt; d_is_store = x.st;
      d_mdu = x.mdu; e_branch_taken = x.br;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, t, act, want);
      end
   endtask

   // does instruction x read register r (r0 never counts)
   function automatic bit reads(input din_t x, input logic [4:0] r);
      return x.v && (r != 5'd0) &&
             ((x.urs && x.rs == r) || ((x.urt || x.st) && x.rt == r));
   endfunction

   function automatic int code(input din_t x, input logic used, input logic [4:0] src);
      if (!x.v || !used || src == 5'd0) return 0;
      if (hist[0].wreg && !hist[0].m2reg && hist[0].rn == src) return 1;
      if (hist[1].wreg && hist[1].rn == src) return hist[1].m2reg ? 3 : 2;
      return 0;
   endfunction

   task automatic model_reset();
      rec_t z;
      z.rn = 5'd0; z.wreg = 1'b0; z.m2reg = 1'b0;
      hist.delete();
      hist.push_back(z);
      hist.push_back(z);
      t = 0; mdu_end = 0; mdu_reg = 5'd0; m_sc = 0; m_fc = 0;
   endtask

   task automatic model_eval(input din_t x, output exp_t e);
      bit busy, lu, mh;
      busy = (t < mdu_end);
      lu   = hist[0].wreg && hist[0].m2reg && reads(x, hist[0].rn);
      mh   = busy && x.v && (x.mdu || reads(x, mdu_reg));
      e.a = code(x, x.urs, x.rs);
      e.b = code(x, x.urt, x.rt);
      e.s = code(x, x.st, x.rt);
      e.flush  = int'(x.br);
      e.stall  = int'((lu || mh) && !x.br);
      e.bubble = int'(lu || mh || x.br);
      e.busy   = int'(busy);
      e.sc = m_sc;
      e.fc = m_fc;
   endtask

   task automatic model_commit(input din_t x, input exp_t e);
      rec_t r;
      if (e.stall != 0) m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
      if (e.flush != 0) m_fc = (m_fc < SAT) ? m_fc + 1 : SAT;
      if (e.bubble == 0 && x.v && x.mdu) begin
         mdu_end = t + 1 + LAT;
         mdu_reg = x.rn;
      end
      if (e.bubble != 0 || !x.v) begin
         r.rn = 5'd0; r.wreg = 1'b0; r.m2reg = 1'b0;
      end else begin
         r.rn = x.rn; r.wreg = x.wreg; r.m2reg = x.m2reg;
      end
      hist.push_front(r);
      void'(hist.pop_back());
      t++;
   endtask

   // apply one instruction for one cycle and compare against the model
   task automatic run_cycle(input din_t x);
      exp_t e;
      @(negedge clk);
      drive(x);
      #2;
      model_eval(x, e);
      chk("dadepen",   32'(dadepen),   e.a);
      chk("dbdepen",   32'(dbdepen),   e.b);
      chk("dsdepen",   32'(dsdepen),   e.s);
      chk("d_stall",   32'(d_stall),   e.stall);
      chk("d_bubble",  32'(d_bubble),  e.bubble);
      chk("d_flush",   32'(d_flush),   e.flush);
      chk("mdu_busy",  32'(mdu_busy),  e.busy);
      chk("stall_cnt", 32'(stall_cnt), e.sc);
      chk("flush_cnt", 32'(flush_cnt), e.fc);
      model_commit(x, e);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_dadepen"},   32'(dadepen),   0);
      chk({tag, "_dbdepen"},   32'(dbdepen),   0);
      chk({tag, "_dsdepen"},   32'(dsdepen),   0);
      chk({tag, "_d_stall"},   32'(d_stall),   0);
      chk({tag, "_d_bubble"},  32'(d_bubble),  0);
      chk({tag, "_d_flush"},   32'(d_flush),   0);
      chk({tag, "_mdu_busy"},  32'(mdu_busy),  0);
      chk({tag, "_stall_cnt"}, 32'(stall_cnt), 0);
      chk({tag, "_flush_cnt"}, 32'(flush_cnt), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      clrn = 1'b0;
      drive(nop());
      #2;
      chk_all_zero("rst");
      @(negedge clk);
      clrn = 1'b1;
      model_reset();
   endtask

   task automatic setv(input int i, input din_t in, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] s, input logic stall, input logic flush, input logic busy);
      vec[i].in = in; vec[i].a = a; vec[i].b = b; vec[i].s = s;
      vec[i].stall = stall; vec[i].flush = flush; vec[i].busy = busy;
   endtask

   initial begin
      //                              a  b  s  stl fl busy
      setv( 0, alu(3, 1, 2),          0, 0, 0, 0, 0, 0);
      setv( 1, alu(4, 3, 1),          1, 0, 0, 0, 0, 0);  // back-to-back ALU
      setv( 2, alu(3, 1, 2),          0, 0, 0, 0, 0, 0);
      setv( 3, nop(),                 0, 0, 0, 0, 0, 0);
      setv( 4, alu(4, 3, 1),          2, 0, 0, 0, 0, 0);  // one NOP between
      setv( 5, ld(5, 2),              0, 0, 0, 0, 0, 0);
      setv( 6, alu(6, 5, 2),          0, 0, 0, 1, 0, 0);  // load-use
      setv( 7, alu(6, 5, 2),          3, 0, 0, 0, 0, 0);
      setv( 8, ld(7, 1),              0, 0, 0, 0, 0, 0);
      setv( 9, sw(7, 2),              0, 0, 0, 1, 0, 0);  // store data after load
      setv(10, sw(7, 2),              0, 0, 3, 0, 0, 0);
      setv(11, mduop(8, 1, 2),        0, 0, 0, 0, 0, 0);
      setv(12, alu(9, 8, 0),          1, 0, 0, 1, 0, 1);
      setv(13, alu(9, 8, 0),          2, 0, 0, 1, 0, 1);
      setv(14, alu(9, 8, 0),          0, 0, 0, 1, 0, 1);
      setv(15, alu(9, 8, 0),          0, 0, 0, 1, 0, 1);
      setv(16, alu(9, 8, 0),          0, 0, 0, 0, 0, 0);  // released
      setv(17, ld(11, 1),             0, 0, 0, 0, 0, 0);
      setv(18, withbr(alu(12, 11, 2)),0, 0, 0, 0, 1, 0);  // flush beats load-use
      setv(19, alu(13, 12, 11),       0, 3, 0, 0, 0, 0);  // E slot was emptied

      // reset state, with a branch asserted to show outputs stay low
      clrn = 1'b0;
      drive(withbr(alu(1, 2, 3)));
      model_reset();
      #2;
      chk_all_zero("init");
      @(negedge clk);
      clrn = 1'b1;
      drive(nop());

      // directed table
      for (int i = 0; i < 20; i++) begin
         run_cycle(vec[i].in);
         chk($sformatf("tbl%0d_a", i),     32'(dadepen),  32'(vec[i].a));
         chk($sformatf("tbl%0d_b", i),     32'(dbdepen),  32'(vec[i].b));
         chk($sformatf("tbl%0d_s", i),     32'(dsdepen),  32'(vec[i].s));
         chk($sformatf("tbl%0d_stall", i), 32'(d_stall),  32'(vec[i].stall));
         chk($sformatf("tbl%0d_flush", i), 32'(d_flush),  32'(vec[i].flush));
         chk($sformatf("tbl%0d_busy", i),  32'(mdu_busy), 32'(vec[i].busy));
      end
      chk("tbl_stall_total", 32'(stall_cnt), 6);
      chk("tbl_flush_total", 32'(flush_cnt), 1);

      // branch taken while the MDU is busy: MDU keeps running
      do_reset();
      run_cycle(mduop(8, 1, 2));
      run_cycle(withbr(alu(9, 8, 0)));
      chk("brbusy_flush", 32'(d_flush), 1);
      chk("brbusy_stall", 32'(d_stall), 0);
      chk("brbusy_busy",  32'(mdu_busy), 1);
      for (int i = 0; i < 3; i++) begin
         run_cycle(alu(9, 8, 0));
         chk("brbusy_busy_n",  32'(mdu_busy), 1);
         chk("brbusy_stall_n", 32'(d_stall), 1);
      end
      run_cycle(alu(9, 8, 0));
      chk("brbusy_release", 32'(mdu_busy), 0);
      chk("brbusy_cnt", 32'(stall_cnt), 3);

      // reset asserted while BUSY with a stall pending
      do_reset();
      run_cycle(mduop(8, 1, 2));
      run_cycle(alu(9, 8, 0));
      chk("midrst_pre_stall", 32'(d_stall), 1);
      @(negedge clk);
      drive(withbr(alu(9, 8, 0)));
      clrn = 1'b0;
      #1;
      chk_all_zero("midrst");
      @(negedge clk);
      clrn = 1'b1;
      drive(nop());
      model_reset();
      run_cycle(alu(9, 8, 0));
      chk("midrst_after_stall", 32'(d_stall), 0);
      chk("midrst_after_busy",  32'(mdu_busy), 0);

      // random traffic against the reference model (counters saturate at 15)
      do_reset();
      for (int n = 0; n < 600; n++) begin
         din_t x;
         x.v     = ($urandom_range(0, 7) != 0);
         x.rs    = 5'($urandom_range(0, 5));
         x.rt    = 5'($urandom_range(0, 5));
         x.rn    = 5'($urandom_range(0, 5));
         x.wreg  = 1'($urandom_range(0, 1));
         x.m2reg = ($urandom_range(0, 2) == 0);
         x.urs   = 1'($urandom_range(0, 1));
         x.urt   = 1'($urandom_range(0, 1));
         x.st    = ($urandom_range(0, 3) == 0);
         x.mdu   = ($urandom_range(0, 5) == 0);
         x.br    = ($urandom_range(0, 7) == 0);
         run_cycle(x);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
